acs_unit: RTL

ACS_UNIT -- requirements
Module: acs_unit

---
 rtl/acs_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/acs_unit.sv
// Add-compare-select unit for a 4-state (K=3, generators 7/5) Viterbi trellis.
// Define ACS_NORM_EN to renormalise metrics instead of saturating them.
module acs_unit #(
  parameter int PM_W      = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bm_valid,
  input  logic [1:0] bm00,
  input  logic [1:0] bm01,
  input  logic [1:0] bm10,
  input  logic [1:0] bm11,
  output logic       dec_valid,
  output logic [3:0] dec,
  output logic       frame_done,
  output logic [1:0] best_state,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 2);
  localparam logic [PM_W:0]   HALF_X  = (PM_W + 1)'(1) << (PM_W - 1);
  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [7:0]      LAST_STEP = 8'(FRAME_LEN - 1);

  logic [1:0]            state_r;
  logic [7:0]            cnt_r;
  logic [3:0][PM_W-1:0]  pm_r;

  logic [3:0][1:0]       bm_tab_s;
  logic [3:0][1:0]       sym_a_s;
  logic [3:0][1:0]       sym_b_s;
  logic [3:0][PM_W:0]    cand_a_s;
  logic [3:0][PM_W:0]    cand_b_s;
  logic [3:0][PM_W:0]    sel_s;
  logic [3:0]            hi_s;
  logic [3:0][PM_W-1:0]  pm_nxt_s;
  logic [3:0]            dec_nxt_s;
  logic                  step_s;

  // Lowest index wins among equal minima.
  function automatic logic [1:0] argmin(input logic [3:0][PM_W-1:0] m);
    logic [1:0]      idx;
    logic [PM_W-1:0] v;
    idx = 2'd0;
    v   = m[0];
    for (int n = 1; n < 4; n++) begin
      if (m[n] < v) begin
        idx = 2'(n);
        v   = m[n];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign step_s = (state_r == RUN) && bm_valid && !start;

  // Butterfly: next state ns={u,s1} is reached from {ns0,0} (pA) or {ns0,1} (pB).
  always_comb begin
    bm_tab_s  = {bm11, bm10, bm01, bm00};
    sym_a_s   = '0;
    sym_b_s   = '0;
    cand_a_s  = '0;
    cand_b_s  = '0;
    sel_s     = '0;
    hi_s      = 4'b0000;
    pm_nxt_s  = '0;
    dec_nxt_s = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      sym_a_s[n]  = {n[1], n[1] ^ n[0]};
      sym_b_s[n]  = {~n[1], ~(n[1] ^ n[0])};
      cand_a_s[n] = {1'b0, pm_r[{n[0], 1'b0}]} + {{(PM_W-1){1'b0}}, bm_tab_s[sym_a_s[n]]};
      cand_b_s[n] = {1'b0, pm_r[{n[0], 1'b1}]} + {{(PM_W-1){1'b0}}, bm_tab_s[sym_b_s[n]]};
      if (cand_b_s[n] < cand_a_s[n]) begin
        sel_s[n]     = cand_b_s[n];
        dec_nxt_s[n] = 1'b1;
      end else begin
        sel_s[n]     = cand_a_s[n];
        dec_nxt_s[n] = 1'b0;
      end
      hi_s[n] = sel_s[n][PM_W] | sel_s[n][PM_W-1];
    end
    for (int n = 0; n < 4; n++) begin
`ifdef ACS_NORM_EN
      pm_nxt_s[n] = (&hi_s) ? PM_W'(sel_s[n] - HALF_X) : sel_s[n][PM_W-1:0];
`else
      pm_nxt_s[n] = sel_s[n][PM_W] ? PM_MAX : sel_s[n][PM_W-1:0];
`endif
    end
  end

  // Frame control, metric registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      pm_r       <= '0;
      dec        <= 4'b0000;
      dec_valid  <= 1'b0;
      frame_done <= 1'b0;
      best_state <= 2'd0;
      busy       <= 1'b0;
    end else if (start) begin
      state_r    <= RUN;
      cnt_r      <= 8'd0;
      pm_r       <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
      dec_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b1;
    end else begin
      dec_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
        end
        RUN: begin
          if (step_s) begin
            pm_r      <= pm_nxt_s;
            dec       <= dec_nxt_s;
            dec_valid <= 1'b1;
            if (cnt_r == LAST_STEP) begin
              state_r    <= DONE;
              cnt_r      <= 8'd0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              best_state <= argmin(pm_nxt_s);
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
